// File: rtl/alu_pkg.sv
// Shared types for the ALU issue/writeback sequencer: ALU select encoding and
// sequencer FSM states.
package alu_pkg;

    localparam int unsigned OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        ALU_PASS = 2'b00,
        ALU_ADD  = 2'b01,
        ALU_SUB  = 2'b10,
        ALU_CLR  = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        EXEC  = 2'b10,
        WRITE = 2'b11
    } seq_state_t;

endpackage

// File: rtl/alu_regfile.sv
// NREGS x WIDTH register file: writeback and external write ports (writeback
// has priority on the same index), two operand read ports and a debug read port.
module alu_regfile #(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned NREGS = 8,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wb_en_i,
    input  logic [AW-1:0]    wb_addr_i,
    input  logic [WIDTH-1:0] wb_data_i,
    input  logic             ext_en_i,
    input  logic [AW-1:0]    ext_addr_i,
    input  logic [WIDTH-1:0] ext_data_i,
    input  logic [AW-1:0]    rs1_addr_i,
    output logic [WIDTH-1:0] rs1_data_c_o,
    input  logic [AW-1:0]    rs2_addr_i,
    output logic [WIDTH-1:0] rs2_data_c_o,
    input  logic [AW-1:0]    dbg_addr_i,
    output logic [WIDTH-1:0] dbg_data_c_o
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];

    // External write applied first so a same-index writeback overrides it
    always_comb begin
        for (int i = 0; i < int'(NREGS); i++) begin
            regs_d[i] = regs_q[i];
        end
        if (ext_en_i) begin
            regs_d[ext_addr_i] = ext_data_i;
        end
        if (wb_en_i) begin
            regs_d[wb_addr_i] = wb_data_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign rs1_data_c_o = regs_q[rs1_addr_i];
    assign rs2_data_c_o = regs_q[rs2_addr_i];
    assign dbg_data_c_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue/writeback controller in front of a combinational ALU: accepts one
// instruction, drives registered ALU inputs, captures the result, writes back.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned NREGS = 8,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [1:0]       instr_op,
    input  logic [AW-1:0]    instr_rd,
    input  logic [AW-1:0]    instr_rs1,
    input  logic [AW-1:0]    instr_rs2,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    output logic             done,
    output logic [AW-1:0]    done_rd,
    output logic [WIDTH-1:0] done_data,
    output logic             zero
);

    seq_state_t       state_q, state_d;
    alu_op_t          op_q, op_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW-1:0]    rs1_q, rs1_d;
    logic [AW-1:0]    rs2_q, rs2_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    alu_op_t          alu_sel_q, alu_sel_d;
    logic             done_q, done_d;
    logic [AW-1:0]    done_rd_q, done_rd_d;
    logic [WIDTH-1:0] done_data_q, done_data_d;
    logic             zero_q, zero_d;

    logic [WIDTH-1:0] rs1_data_c;
    logic [WIDTH-1:0] rs2_data_c;
    logic             accept_c;
    logic             wb_en_c;

    assign instr_ready = (state_q == IDLE) && !reset;
    assign accept_c    = instr_valid && instr_ready;
    assign wb_en_c     = (state_q == WRITE);

    alu_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_regfile (
        .clk          (clk),
        .reset        (reset),
        .wb_en_i      (wb_en_c),
        .wb_addr_i    (done_rd_q),
        .wb_data_i    (done_data_q),
        .ext_en_i     (wr_en),
        .ext_addr_i   (wr_addr),
        .ext_data_i   (wr_data),
        .rs1_addr_i   (rs1_q),
        .rs1_data_c_o (rs1_data_c),
        .rs2_addr_i   (rs2_q),
        .rs2_data_c_o (rs2_data_c),
        .dbg_addr_i   (dbg_addr),
        .dbg_data_c_o (dbg_data)
    );

    // Result/done registers load at the end of EXEC so they are live during WRITE
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rd_d        = rd_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        done_d      = 1'b0;
        done_rd_d   = done_rd_q;
        done_data_d = done_data_q;
        zero_d      = zero_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    op_d    = alu_op_t'(instr_op);
                    rd_d    = instr_rd;
                    rs1_d   = instr_rs1;
                    rs2_d   = instr_rs2;
                    state_d = READ;
                end
            end
            READ: begin
                alu_a_d   = rs1_data_c;
                alu_b_d   = rs2_data_c;
                alu_sel_d = op_q;
                state_d   = EXEC;
            end
            EXEC: begin
                done_d      = 1'b1;
                done_rd_d   = rd_q;
                done_data_d = alu_result;
                zero_d      = (alu_result == '0);
                state_d     = WRITE;
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= ALU_PASS;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= ALU_PASS;
            done_q      <= 1'b0;
            done_rd_q   <= '0;
            done_data_q <= '0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            done_q      <= done_d;
            done_rd_q   <= done_rd_d;
            done_data_q <= done_data_d;
            zero_q      <= zero_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = 2'(alu_sel_q);
    assign done      = done_q;
    assign done_rd   = done_rd_q;
    assign done_data = done_data_q;
    assign zero      = zero_q;

endmodule
